// File: rtl/mux_rr_arbiter.sv
// Two-input round-robin arbiter with valid/ready handshakes and a registered output word.
// Drives the select line of a downstream 2:1 mux and keeps per-source grant counters.
module mux_rr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic               prio_q;
    logic [WIDTH-1:0]   y_data_q;
    logic               sel_q;
    logic [CNT_W-1:0]   cnt_a_q, cnt_b_q;

    logic               load;
    logic               grant_a;
    logic               grant_b;

    // prio_q: 0 favours A, 1 favours B; it only matters when both request.
    always_comb begin
        load    = (state_q == StEmpty) || y_ready;
        grant_a = load && a_valid && (!b_valid || !prio_q);
        grant_b = load && b_valid && (!a_valid || prio_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (grant_a || grant_b) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (y_ready) begin
                    state_d = (grant_a || grant_b) ? StFull : StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Data path: only a grant moves y_data, sel, prio or the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data_q <= '0;
            sel_q    <= 1'b0;
            prio_q   <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
        end else if (grant_a) begin
            y_data_q <= a_data;
            sel_q    <= 1'b0;
            prio_q   <= 1'b1;
            cnt_a_q  <= cnt_a_q + CNT_W'(1);
        end else if (grant_b) begin
            y_data_q <= b_data;
            sel_q    <= 1'b1;
            prio_q   <= 1'b0;
            cnt_b_q  <= cnt_b_q + CNT_W'(1);
        end
    end

    // Readys are held low while reset is asserted, even if a source is valid.
    always_comb begin
        a_ready = rst_n && grant_a;
        b_ready = rst_n && grant_b;
        y_valid = (state_q == StFull);
        y_data  = y_data_q;
        sel     = sel_q;
        cnt_a   = cnt_a_q;
        cnt_b   = cnt_b_q;
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed table, hand sequences and random traffic
// checked against a transaction-level reference model.
module tb_mux_rr_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             a_valid, b_valid, y_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, y_valid, sel;
    logic [WIDTH-1:0] y_data;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    logic             a_ready4, b_ready4, y_valid4, sel4;
    logic [WIDTH-1:0] y_data4;
    logic [3:0]       cnt4_a, cnt4_b;

    int n_tests;
    int n_fail;

    // Reference model state: holding register contents, last winner and grant totals.
    bit               m_full;
    logic [WIDTH-1:0] m_data;
    bit               m_sel;
    int               m_last;    // -1: nobody granted since reset (A favoured)
    int               m_ca, m_cb;

    mux_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    mux_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
        .y_valid(y_valid4), .y_data(y_data4), .y_ready(y_ready),
        .sel(sel4), .cnt_a(cnt4_a), .cnt_b(cnt4_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner of this cycle: 0 = A, 1 = B, -1 = nobody.
    function automatic int pick(input bit av, input bit bv, input bit yr);
        bit b_turn;
        if (m_full && !yr) return -1;
        b_turn = (m_last == 0);
        if (av && bv) return b_turn ? 1 : 0;
        if (av) return 0;
        if (bv) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_full = 0; m_data = '0; m_sel = 0; m_last = -1; m_ca = 0; m_cb = 0;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit av, input logic [WIDTH-1:0] ad,
                         input bit bv, input logic [WIDTH-1:0] bd, input bit yr);
        int w;
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
        #1;
        w = pick(av, bv, yr);
        chk("a_ready", {31'b0, a_ready}, {31'b0, w == 0});
        chk("b_ready", {31'b0, b_ready}, {31'b0, w == 1});
        @(posedge clk);
        if (w == 0) begin
            m_full = 1; m_data = ad; m_sel = 0; m_last = 0; m_ca++;
        end else if (w == 1) begin
            m_full = 1; m_data = bd; m_sel = 1; m_last = 1; m_cb++;
        end else if (yr) begin
            m_full = 0;
        end
        #1;
        chk("y_valid", {31'b0, y_valid}, {31'b0, m_full});
        chk("y_data", {24'b0, y_data}, {24'b0, m_data});
        chk("sel", {31'b0, sel}, {31'b0, m_sel});
        chk("cnt_a", {16'b0, cnt_a}, m_ca % 65536);
        chk("cnt_b", {16'b0, cnt_b}, m_cb % 65536);
        chk("cnt4_a", {28'b0, cnt4_a}, m_ca % 16);
        chk("cnt4_b", {28'b0, cnt4_b}, m_cb % 16);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hEE; b_data = 8'hDD; y_ready = 1'b1;
        #1;
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
        chk("rst_y_valid", {31'b0, y_valid}, 32'd0);
        chk("rst_y_data", {24'b0, y_data}, 32'd0);
        chk("rst_sel", {31'b0, sel}, 32'd0);
        chk("rst_cnt_a", {16'b0, cnt_a}, 32'd0);
        chk("rst_cnt_b", {16'b0, cnt_b}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         av;
        logic [7:0] ad;
        bit         bv;
        logic [7:0] bd;
        bit         yr;
        bit         exp_ar;
        bit         exp_br;
        bit         exp_yv;
        logic [7:0] exp_yd;
        bit         exp_sel;
    } vec_t;

    vec_t vecs[10];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        //        av  ad     bv  bd     yr  ar  br  yv  yd     sel
        vecs[0] = '{1, 8'h11, 0, 8'h00, 1, 1, 0, 1, 8'h11, 0};
        vecs[1] = '{1, 8'h0A, 1, 8'h0B, 1, 0, 1, 1, 8'h0B, 1};
        vecs[2] = '{1, 8'h0A, 1, 8'h0B, 1, 1, 0, 1, 8'h0A, 0};
        vecs[3] = '{1, 8'h0A, 1, 8'h0B, 0, 0, 0, 1, 8'h0A, 0};
        vecs[4] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h0A, 0};
        vecs[5] = '{0, 8'h00, 1, 8'h22, 0, 0, 1, 1, 8'h22, 1};
        vecs[6] = '{1, 8'h33, 0, 8'h00, 0, 0, 0, 1, 8'h22, 1};
        vecs[7] = '{1, 8'h44, 1, 8'h55, 1, 1, 0, 1, 8'h44, 0};
        vecs[8] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 8'h44, 0};
        vecs[9] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h44, 0};

        @(posedge clk);
        #1;
        do_reset();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            a_valid = vecs[i].av; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_data = vecs[i].bd; y_ready = vecs[i].yr;
            #1;
            chk("tbl_a_ready", {31'b0, a_ready}, {31'b0, vecs[i].exp_ar});
            chk("tbl_b_ready", {31'b0, b_ready}, {31'b0, vecs[i].exp_br});
            cycle(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].yr);
            chk("tbl_y_valid", {31'b0, y_valid}, {31'b0, vecs[i].exp_yv});
            chk("tbl_y_data", {24'b0, y_data}, {24'b0, vecs[i].exp_yd});
            chk("tbl_sel", {31'b0, sel}, {31'b0, vecs[i].exp_sel});
        end

        // Fairness under continuous dual requests, starting with A after reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 8'h0A, 1, 8'h0B, 1);
            chk("fair_y_data", {24'b0, y_data}, (i % 2 == 1) ? 32'h0B : 32'h0A);
            chk("fair_sel", {31'b0, sel}, i % 2);
        end
        chk("fair_cnt_a", {16'b0, cnt_a}, 32'd3);
        chk("fair_cnt_b", {16'b0, cnt_b}, 32'd3);

        // Output stall, then release grants in the same cycle
        do_reset();
        cycle(1, 8'h0A, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 8'h0A, 1, 8'h0B, 0);
            chk("stall_y_data", {24'b0, y_data}, 32'h0A);
            chk("stall_sel", {31'b0, sel}, 32'd0);
        end
        y_ready = 1'b1;
        #1;
        chk("stall_release_b_ready", {31'b0, b_ready}, 32'd1);
        cycle(1, 8'h0A, 1, 8'h0B, 1);

        // Lone requester keeps the next contested turn for the other side
        do_reset();
        cycle(1, 8'h01, 0, 8'h00, 1);
        cycle(1, 8'h02, 1, 8'h03, 1);
        chk("lone_sel", {31'b0, sel}, 32'd1);
        chk("lone_y_data", {24'b0, y_data}, 32'h03);

        // Asynchronous reset while holding a word
        do_reset();
        cycle(1, 8'h55, 0, 8'h00, 0);
        chk("pre_rst_y_data", {24'b0, y_data}, 32'h55);
        do_reset();

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            cycle(1, 8'(i), 0, 8'h00, 1);
        end
        chk("wrap_cnt4_a", {28'b0, cnt4_a}, 32'd1);
        chk("wrap_cnt_a", {16'b0, cnt_a}, 32'd17);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom),
                  ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Two-input round-robin arbiter with valid/ready handshakes. It sits directly upstream of `mux_2to1` and decides which source, `a` or `b`, is forwarded. It registers the winning word and drives the `sel` line (0 = `a`, 1 = `b`) for the downstream 2:1 select. It also keeps per-source grant counters for debug.

## Interface
- `WIDTH`, 8: data width of both sources and the output.
- `CNT_W`, 16: width of the per-source grant counters.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`  in  1  source A presents a word.
- `a_data`  in  WIDTH  source A word.
- `a_ready`  out  1  source A word accepted this cycle.
- `b_valid`  in  1  source B presents a word.
- `b_data`  in  WIDTH  source B word.
- `b_ready`  out  1  source B word accepted this cycle.
- `y_valid`  out  1  output register holds a word.
- `y_data`  out  WIDTH  registered winning word.
- `y_ready`  in  1  consumer takes `y_data` this cycle.
- `sel`  out  1  source of the word in `y_data`: 0 = A, 1 = B. Feeds the `sel` of `mux_2to1`.
- `cnt_a`  out  CNT_W  number of A words accepted.
- `cnt_b`  out  CNT_W  number of B words accepted.

## Operation
- Output FSM has two states:
  - EMPTY: `y_valid`=0.
  - FULL: `y_valid`=1.
- `load = !y_valid || y_ready`. The register can accept a new word this cycle.
- Priority pointer `prio`: 0 = A favoured, 1 = B favoured.
- Grant, evaluated only when `load`=1:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source `prio` favours.
  - Neither valid: no grant.
- `a_ready = load && grant_a` and `b_ready = load && grant_b`. Both are combinational from the valids, `y_valid`, `y_ready` and `prio`. Never both 1 in the same cycle.
- On a grant at the clock edge:
  - `y_data` takes the granted word.
  - `sel` takes the granted index.
  - `y_valid` goes to 1.
  - `prio` moves to favour the other source.
  - The granted counter increments.
- FSM transitions:
  - EMPTY + grant → FULL.
  - EMPTY + no grant → EMPTY.
  - FULL + `y_ready`=0 → FULL. `y_data`, `sel` and `prio` hold; both readys are 0.
  - FULL + `y_ready`=1 + grant → FULL with the new word (back-to-back, no bubble).
  - FULL + `y_ready`=1 + no grant → EMPTY. `y_data` and `sel` hold their last values.
- `prio` changes only on a grant. A lone requester does not lose its turn when the other source later arrives. Example: A wins alone, `prio` becomes 1, and B wins the next contested cycle.
- Counters wrap modulo 2^CNT_W and never saturate.
- A source that drops `valid` before its ready is simply not granted. No state is retained for it.

## Timing
- Reset values (`rst_n`=0, asynchronous):
  - `y_valid`=0, `y_data`=0, `sel`=0, `prio`=0, `cnt_a`=0, `cnt_b`=0.
  - `a_ready` and `b_ready` are forced to 0 while `rst_n`=0.
- Reset asserted mid-transfer discards the held word immediately. No output handshake completes in that cycle.
- First cycle after reset release: the bench can get a ready combinationally if a valid is present.
- Latency: one clock from input handshake to `y_valid`=1 with that word.
- Throughput: one word per clock while `y_ready`=1.
- Fairness: under continuous dual requests, grants alternate strictly A, B, A, B… starting with A after reset.
- `y_data`, `y_valid` and `sel` are registered outputs with no combinational path from inputs.
- `a_ready`/`b_ready` have a combinational path from `y_ready`, `a_valid` and `b_valid`.

## Test plan
- Reset, then only `a_valid`=1 with `a_data`=0x11 and `y_ready`=1:
  - `a_ready`=1 in cycle 0.
  - Next cycle `y_valid`=1, `y_data`=0x11, `sel`=0, `cnt_a`=1.
- Both valid continuously (A=0x0A, B=0x0B), `y_ready`=1, 6 cycles:
  - `y_data` sequence 0x0A, 0x0B, 0x0A, 0x0B, 0x0A, 0x0B.
  - `sel` toggles 0, 1, 0, 1…
  - `cnt_a`=3, `cnt_b`=3.
- Output stall: one word loaded, then `y_ready`=0 for 4 cycles with both valid:
  - `a_ready`=`b_ready`=0 throughout.
  - `y_data` and `sel` stable.
  - Raising `y_ready` causes the next grant in the same cycle.
- Lone-source priority: A alone for 1 grant, then both valid:
  - B wins the contested cycle (`sel`=1).
- Reset asserted while FULL with `y_data`=0x55:
  - `y_valid`, `y_data`, `sel`, `cnt_a` and `cnt_b` go to 0 without waiting for a clock edge.
- `CNT_W`=4, 17 A grants: `cnt_a`=1 (wrapped).
